// File: rtl/slot_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : slot_rom_arbiter
//  Description : Apple II peripheral ROM arbiter. Decodes the per-slot Cnxx
//                pages and the shared $C800-$CFFF expansion window, tracks
//                which slot card owns the expansion window, and holds the
//                INTCXROM / SLOTC3ROM / INTC8ROM soft switches.
//  Ports       : CLK_14M, RESET (sync, active-high), BUS_CE (one pulse per
//                6502 cycle), ADDRESS[15:0], RW_N (1 = read)
//                IO_SELECT_N[6:0]     active-low Cnxx select, bit k = slot k+1
//                DEVICE_SELECT_N[6:0] active-low $C0n0-$C0nF select
//                IO_STROBE_N          active-low, $C800-$CFFF routed to slots
//                SLOT_ROM_EN[6:0]     one-hot current expansion ROM owner
//                C8_OWNER[2:0]        0 = none, 1-7 = owning slot
//                INT_ROM_SEL          current address served by internal ROM
//                INTCXROM, SLOTC3ROM, INTC8ROM  soft-switch state
//  Revision    : 1.0  initial release
// ============================================================================
module slot_rom_arbiter #(
    parameter logic RESET_SLOTC3ROM = 1'b0
) (
    input  logic        CLK_14M,
    input  logic        RESET,
    input  logic        BUS_CE,
    input  logic [15:0] ADDRESS,
    input  logic        RW_N,
    output logic [6:0]  IO_SELECT_N,
    output logic [6:0]  DEVICE_SELECT_N,
    output logic        IO_STROBE_N,
    output logic [6:0]  SLOT_ROM_EN,
    output logic [2:0]  C8_OWNER,
    output logic        INT_ROM_SEL,
    output logic        INTCXROM,
    output logic        SLOTC3ROM,
    output logic        INTC8ROM
);

    logic [2:0] r_c8_owner;
    logic [6:0] r_slot_rom_en;
    logic       r_intcxrom;
    logic       r_slotc3rom;
    logic       r_intc8rom;

    logic       w_cn_page;
    logic [2:0] w_cn_num;
    logic       w_cn_routed;
    logic       w_c3_internal;
    logic       w_c8_page;
    logic       w_c8_routed;
    logic [6:0] w_sel_onehot;

    // $C100-$C7FF: top five bits 11000 and a nonzero slot number
    assign w_cn_num    = ADDRESS[10:8];
    assign w_cn_page   = (ADDRESS[15:11] == 5'b11000) && (w_cn_num != 3'd0);
    assign w_cn_routed = w_cn_page && !r_intcxrom &&
                         !((w_cn_num == 3'd3) && !r_slotc3rom);
    // Slot 3 page served internally, whichever switch caused it
    assign w_c3_internal = w_cn_page && (w_cn_num == 3'd3) && !w_cn_routed;

    assign w_c8_page   = (ADDRESS[15:11] == 5'b11001);
    assign w_c8_routed = w_c8_page && !r_intcxrom && !r_intc8rom;

    genvar k;
    generate
        for (k = 0; k < 7; k++) begin : g_slot
            assign w_sel_onehot[k]    = w_cn_routed && (w_cn_num == 3'(k + 1));
            assign DEVICE_SELECT_N[k] = ~(ADDRESS[15:4] == 12'(12'hC09 + k));
        end
    endgenerate

    assign IO_SELECT_N = ~w_sel_onehot;
    assign IO_STROBE_N = ~w_c8_routed;
    assign INT_ROM_SEL = (w_cn_page && !w_cn_routed) || (w_c8_page && !w_c8_routed);

    // SLOT_ROM_EN is kept as its own register so cards see a clean enable
    // that never glitches while ADDRESS settles.
    assign SLOT_ROM_EN = r_slot_rom_en;
    assign C8_OWNER    = r_c8_owner;
    assign INTCXROM    = r_intcxrom;
    assign SLOTC3ROM   = r_slotc3rom;
    assign INTC8ROM    = r_intc8rom;

    always_ff @(posedge CLK_14M) begin
        if (RESET) begin
            r_c8_owner    <= 3'd0;
            r_slot_rom_en <= 7'd0;
            r_intcxrom    <= 1'b0;
            r_slotc3rom   <= RESET_SLOTC3ROM;
            r_intc8rom    <= 1'b0;
        end else if (BUS_CE) begin
            // Soft switches respond to writes only
            if (!RW_N) begin
                case (ADDRESS)
                    16'hC006: r_intcxrom  <= 1'b0;
                    16'hC007: r_intcxrom  <= 1'b1;
                    16'hC00A: r_slotc3rom <= 1'b0;
                    16'hC00B: r_slotc3rom <= 1'b1;
                    default:  ;
                endcase
            end
            // Ownership follows any access type; $CFFF release has priority
            if (ADDRESS == 16'hCFFF) begin
                r_c8_owner    <= 3'd0;
                r_slot_rom_en <= 7'd0;
                r_intc8rom    <= 1'b0;
            end else if (w_cn_routed) begin
                r_c8_owner    <= w_cn_num;
                r_slot_rom_en <= w_sel_onehot;
                r_intc8rom    <= 1'b0;
            end else if (w_c3_internal) begin
                r_c8_owner    <= 3'd0;
                r_slot_rom_en <= 7'd0;
                r_intc8rom    <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/slot_rom_arbiter.md
# slot_rom_arbiter

Arbitrates the Apple II peripheral ROM spaces ($C100–$C7FF per-slot and the shared $C800–$CFFF expansion window) between the seven slot cards and the internal ROM, and generates each slot's select strobes. It tracks which card currently owns $C800–$CFFF (latched on that card's Cnxx access, released on any $CFFF access) and holds the INTCXROM / SLOTC3ROM / INTC8ROM soft-switch state. Sits between the CPU bus decode and the slot cards (e.g. the Super Serial card); cards gate their expansion ROM with SLOT_ROM_EN and IO_STROBE_N instead of tracking ownership themselves.

## Interface
- RESET_SLOTC3ROM, 0: SLOTC3ROM value loaded at reset (0 = internal $C3 ROM).
- CLK_14M  in  1  system clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- BUS_CE  in  1  one-CLK_14M pulse per 6502 bus cycle; ADDRESS/RW_N valid while high.
- ADDRESS  in  16  CPU address.
- RW_N  in  1  1 = read, 0 = write.
- IO_SELECT_N  out  7  bit k = slot k+1, active-low Cnxx select.
- DEVICE_SELECT_N  out  7  bit k = slot k+1, active-low $C0n0–$C0nF select ($C080+16·(k+1)... i.e. $C090 slot 1 through $C0F0 slot 7).
- IO_STROBE_N  out  1  active-low, $C800–$CFFF routed to slots.
- SLOT_ROM_EN  out  7  one-hot of current owner; all zero when no owner.
- C8_OWNER  out  3  0 = none, 1–7 = owning slot.
- INT_ROM_SEL  out  1  current address served by internal ROM.
- INTCXROM, SLOTC3ROM, INTC8ROM  out  1 each  soft-switch state.

## Operation
- Decodes (combinational from ADDRESS and registered state, independent of BUS_CE):
  - slot n (1–7) Cnxx: ADDRESS[15:8]==$C0+n. Routed to slot when INTCXROM=0 and not (n==3 and SLOTC3ROM=0); then IO_SELECT_N[n-1]=0, else internal.
  - DEVICE_SELECT_N[n-1]=0 when ADDRESS[15:4]==$C08+n; never affected by soft switches.
  - $C800–$CFFF (ADDRESS[15:11]==5'b11001): IO_STROBE_N=0 when INTCXROM=0 and INTC8ROM=0, else internal.
  - INT_ROM_SEL=1 for any $C100–$CFFF address not routed to a slot.
- Soft switches, updated on BUS_CE & ~RW_N only: $C006 → INTCXROM=0; $C007 → INTCXROM=1; $C00A → SLOTC3ROM=0; $C00B → SLOTC3ROM=1. Reads of these addresses change nothing.
- Ownership state (C8_OWNER, INTC8ROM), updated on BUS_CE, read or write, priority highest first:
  1. ADDRESS==$CFFF → C8_OWNER=0, INTC8ROM=0.
  2. Cnxx routed to slot n → C8_OWNER=n, INTC8ROM=0.
  3. C3xx served internally (either switch) → INTC8ROM=1, C8_OWNER=0.
  4. otherwise hold.
- Access to Cnxx while INTCXROM=1 with n≠3 does not change ownership.
- SLOT_ROM_EN[k] = (C8_OWNER==k+1); registered-derived, no glitch on address changes.

## Timing
- Reset values: C8_OWNER=0, SLOT_ROM_EN=0, INTC8ROM=0, INTCXROM=0, SLOTC3ROM=RESET_SLOTC3ROM; select outputs follow decode of current ADDRESS under those values.
- Selects and INT_ROM_SEL: zero-cycle combinational from ADDRESS.
- State registers: update on the CLK_14M edge where BUS_CE=1; new value visible next cycle. The $CFFF cycle itself still asserts IO_STROBE_N and the old SLOT_ROM_EN so the old owner drives that read.
- A Cnxx cycle asserts IO_SELECT_N immediately; SLOT_ROM_EN for n valid from the following cycle, before the next BUS_CE.
- BUS_CE=0: no state change regardless of ADDRESS/RW_N.
- RESET=1 concurrent with BUS_CE: reset wins.
- Soft-switch write and ownership rule in the same BUS_CE are on disjoint addresses; no conflict possible.

## Test plan
- Reset, then BUS_CE read $C200 → IO_SELECT_N=7'b1111101, next cycle C8_OWNER=2, SLOT_ROM_EN=7'b0000010; read $C900 → IO_STROBE_N=0.
- Owner 2, read $CFFF → IO_STROBE_N=0 and SLOT_ROM_EN=7'b0000010 in that cycle; next cycle C8_OWNER=0, SLOT_ROM_EN=0.
- SLOTC3ROM=0, read $C300 → IO_SELECT_N=7'h7F, INT_ROM_SEL=1, then INTC8ROM=1; read $C800 → IO_STROBE_N=1, INT_ROM_SEL=1; read $CFFF → INTC8ROM=0.
- Write $C007, read $C500 → IO_SELECT_N=7'h7F, C8_OWNER unchanged; write $C006, read $C500 → C8_OWNER=5.
- Read $C0A8 → DEVICE_SELECT_N=7'b1111101 with INTCXROM both 0 and 1; no state change.
- Owner 6, RESET asserted with BUS_CE on $C100 → C8_OWNER=0, all soft switches at reset values; address toggled with BUS_CE=0 → no state change.
